// File: rtl/tdm_mux_scanner.sv
// Registered N-channel mux with manual select and automatic dwell-timed scan.
// Optional registered parity output enabled by defining TDM_MUX_PARITY_EN.
module tdm_mux_scanner #(
  parameter int  WIDTH    = 1,
  parameter int  CHANNELS = 16,
  parameter int  DWELL    = 1,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  input  logic                      start,
  input  logic                      stop,
  output logic [WIDTH-1:0]          out,
  output logic [SEL_W-1:0]          out_ch,
  output logic                      out_valid,
  output logic                      busy,
  output logic                      wrap
`ifdef TDM_MUX_PARITY_EN
  ,output logic                     out_par
`endif
);
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SEL_W:0]   CH_N  = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST  = SEL_W'(CHANNELS - 1);
  localparam logic [CNT_W-1:0] DLAST = CNT_W'(DWELL - 1);

  typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic [SEL_W-1:0]   ch_q, ch_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               vld_q, vld_d;
  logic               busy_q, busy_d;
  logic               wrap_q, wrap_d;
  logic               man_ok;
  logic [WIDTH-1:0]   man_out;
  logic [SEL_W-1:0]   nxt_ch;

  function automatic logic [WIDTH-1:0] pick(input logic [CHANNELS*WIDTH-1:0] d,
                                            input logic [SEL_W-1:0] s);
    pick = '0;
    for (int c = 0; c < CHANNELS; c++)
      if (s == SEL_W'(c)) pick = d[c*WIDTH +: WIDTH];
  endfunction

  // Out-of-range selects (non power-of-two CHANNELS) present zero, not valid.
  assign man_ok  = {1'b0, sel} < CH_N;
  assign man_out = man_ok ? pick(in, sel) : '0;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    wrap_d  = 1'b0;
    nxt_ch  = ch_q;
    case (state_q)
      IDLE: begin
        vld_d = 1'b0;
        if (start && !stop) begin
          if (mode) begin
            state_d = SCAN;
            ch_d    = '0;
            cnt_d   = '0;
            out_d   = pick(in, '0);
            vld_d   = 1'b1;
          end else begin
            state_d = MANUAL;
            ch_d    = sel;
            out_d   = man_out;
            vld_d   = man_ok;
          end
        end
      end
      MANUAL: begin
        if (stop) begin
          state_d = IDLE;
          vld_d   = 1'b0;
        end else begin
          ch_d  = sel;
          out_d = man_out;
          vld_d = man_ok;
        end
      end
      SCAN: begin
        if (stop) begin
          state_d = IDLE;
          vld_d   = 1'b0;
          cnt_d   = '0;
        end else begin
          if (cnt_q == DLAST) begin
            cnt_d  = '0;
            nxt_ch = (ch_q == LAST) ? '0 : ch_q + 1'b1;
            wrap_d = (ch_q == LAST);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
          // Held channel tracks live input data every cycle.
          ch_d  = nxt_ch;
          out_d = pick(in, nxt_ch);
          vld_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_q   <= '0;
      ch_q    <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      wrap_q  <= wrap_d;
    end
  end

  assign out       = out_q;
  assign out_ch    = ch_q;
  assign out_valid = vld_q;
  assign busy      = busy_q;
  assign wrap      = wrap_q;

`ifdef TDM_MUX_PARITY_EN
  logic par_q, par_d;
  always_comb par_d = ^out_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= par_d;
  end
  assign out_par = par_q;
`endif
endmodule

// File: tb/tb_tdm_mux_scanner.sv
// Directed bench: manual sweep, scan at dwell 1 and 3, stop, range guard, async reset.
module tb_tdm_mux_scanner;
  logic        clk, rst_n, mode, start, stop;
  logic [15:0] in0;
  logic [3:0]  sel0, sel2;
  logic [47:0] in2;
  logic        o0, v0, b0, w0, o1, v1, b1, w1, v2, b2, w2;
  logic [3:0]  c0, c1, c2, o2;
`ifdef TDM_MUX_PARITY_EN
  logic p0, p1, p2;
`endif
  int total = 0, bad = 0;

  tdm_mux_scanner #(.WIDTH(1), .CHANNELS(16), .DWELL(1)) u0 (
    .clk(clk), .rst_n(rst_n), .in(in0), .sel(sel0), .mode(mode), .start(start), .stop(stop),
    .out(o0), .out_ch(c0), .out_valid(v0), .busy(b0), .wrap(w0)
`ifdef TDM_MUX_PARITY_EN
    , .out_par(p0)
`endif
  );
  tdm_mux_scanner #(.WIDTH(1), .CHANNELS(16), .DWELL(3)) u1 (
    .clk(clk), .rst_n(rst_n), .in(in0), .sel(sel0), .mode(mode), .start(start), .stop(stop),
    .out(o1), .out_ch(c1), .out_valid(v1), .busy(b1), .wrap(w1)
`ifdef TDM_MUX_PARITY_EN
    , .out_par(p1)
`endif
  );
  tdm_mux_scanner #(.WIDTH(4), .CHANNELS(12), .DWELL(1)) u2 (
    .clk(clk), .rst_n(rst_n), .in(in2), .sel(sel2), .mode(mode), .start(start), .stop(stop),
    .out(o2), .out_ch(c2), .out_valid(v2), .busy(b2), .wrap(w2)
`ifdef TDM_MUX_PARITY_EN
    , .out_par(p2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sel;
    logic       exp_out;
  } vec_t;
  vec_t vt[16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    start = 1'b0; stop = 1'b0; rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    vt = '{'{4'h0,1'b0}, '{4'h1,1'b1}, '{4'h2,1'b0}, '{4'h3,1'b1},
           '{4'h4,1'b0}, '{4'h5,1'b0}, '{4'h6,1'b0}, '{4'h7,1'b0},
           '{4'h8,1'b1}, '{4'h9,1'b1}, '{4'hA,1'b1}, '{4'hB,1'b1},
           '{4'hC,1'b1}, '{4'hD,1'b1}, '{4'hE,1'b0}, '{4'hF,1'b0}};
    in0 = 16'h3f0a; sel0 = 4'h0; sel2 = 4'h0; mode = 1'b0;
    for (int c = 0; c < 12; c++) in2[c*4 +: 4] = 4'(c);
    do_reset();
    chk("rst_out", {o0, c0, v0, b0, w0}, 0);
    chk("rst_u2", {o2, c2, v2, b2, w2}, 0);

    // Manual sweep, table driven
    mode = 1'b0; start = 1'b1; sel0 = 4'h0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sel0 = vt[i].sel;
      tick();
      chk("man_out", o0, vt[i].exp_out);
      chk("man_ch", c0, vt[i].sel);
      chk("man_vld", v0, 1);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_busy", b0, 0);
    chk("stop_vld", v0, 0);

    // Scan, DWELL=1 on u0 (u1 runs alongside)
    mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("scan0_ch", c0, 0);
    chk("scan0_wrap", w0, 0);
    chk("scan0_vld", v0, 1);
    for (int n = 1; n <= 16; n++) begin
      tick();
      chk("scan_ch", c0, n % 16);
      chk("scan_out", o0, vt[n % 16].exp_out);
      chk("scan_wrap", w0, (n == 16));
    end

    // Scan, DWELL=3 on u1
    do_reset();
    mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("d3_ch0", c1, 0);
    for (int n = 1; n <= 50; n++) begin
      tick();
      chk("d3_ch", c1, (n / 3) % 16);
      chk("d3_out", o1, vt[(n / 3) % 16].exp_out);
      chk("d3_wrap", w1, (n == 48));
    end

    // Stop at channel 5; a start pulse mid-scan is ignored
    do_reset();
    mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      start = (n == 3); mode = (n != 3);
      tick();
    end
    start = 1'b0; mode = 1'b1;
    chk("pre_stop_ch", c0, 5);
    chk("pre_stop_busy", b0, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_ch", c0, 5);
    chk("stop_b", b0, 0);
    chk("stop_v", v0, 0);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("ss_idle_busy", b0, 0);
    chk("ss_idle_ch", c0, 5);
    tick();
    chk("ss_idle_vld", v0, 0);

    // CHANNELS=12 range guard and parity
    do_reset();
    mode = 1'b0; start = 1'b1; sel2 = 4'd13;
    tick();
    start = 1'b0;
    chk("oor_out", o2, 0);
    chk("oor_vld", v2, 0);
    chk("oor_ch", c2, 13);
    sel2 = 4'd11;
    tick();
    chk("c11_out", o2, 4'hB);
    chk("c11_vld", v2, 1);
`ifdef TDM_MUX_PARITY_EN
    chk("c11_par", p2, 1);
`endif
    sel2 = 4'd12;
    tick();
    chk("c12_out", o2, 0);
    chk("c12_vld", v2, 0);
`ifdef TDM_MUX_PARITY_EN
    chk("c12_par", p2, 0);
`endif
    sel2 = 4'd3;
    tick();
    chk("c3_out", o2, 3);
`ifdef TDM_MUX_PARITY_EN
    chk("c3_par", p2, 0);
`endif

    // Async reset mid-scan at channel 7
    do_reset();
    mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 7; n++) tick();
    chk("pre_rst_ch", c0, 7);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_u0", {o0, c0, v0, b0, w0}, 0);
    chk("arst_u2", {o2, c2, v2, b2, w2}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", b0, 0);
    mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_ch", c0, 0);
    chk("restart_vld", v0, 1);
    tick();
    chk("restart_ch1", c0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
